// File: rtl/mux_4to1.sv
// 4:1 data selector with optional output register.
// Also tracks the select code and flags when it changes.
module mux_4to1 #(
  parameter int WIDTH   = 1,
  parameter bit REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] mout,
  output logic [1:0]       sel_q,
  output logic             sel_chg
);

  logic [WIDTH-1:0] mux;

  // Unknown select propagates as X rather than falling back to a.
  always_comb begin
    mux = 'x;
    case (sel)
      2'b00:   mux = a;
      2'b01:   mux = b;
      2'b10:   mux = c;
      2'b11:   mux = d;
      default: mux = 'x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= 2'b00;
      sel_chg <= 1'b0;
    end else begin
      sel_q   <= sel;
      sel_chg <= (sel != sel_q);
    end
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] mout_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) mout_q <= '0;
      else     mout_q <= mux;
    end

    assign mout = mout_q;
  end else begin : g_comb
    assign mout = mux;
  end

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: registered and
// combinational instances driven from shared inputs.
module tb_mux_4to1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b, c, d;
  logic [1:0] sel;
  logic [7:0] mr, mc;
  logic [1:0] sqr, sqc;
  logic       chr, chc;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  mux_4to1 #(.WIDTH(8), .REG_OUT(1)) dut_r (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .sel(sel), .mout(mr), .sel_q(sqr), .sel_chg(chr)
  );

  mux_4to1 #(.WIDTH(8), .REG_OUT(0)) dut_c (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .sel(sel), .mout(mc), .sel_q(sqc), .sel_chg(chc)
  );

  typedef struct {
    logic [1:0] sel;
    logic [7:0] a, b, c, d;
    logic [7:0] mo;
    logic       chg;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pick(input logic [1:0] s,
    input logic [7:0] va, vb, vc, vd);
    case (s)
      2'b00:   return va;
      2'b01:   return vb;
      2'b10:   return vc;
      default: return vd;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] hold;

    vt[0] = '{2'b00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 1'b0};
    vt[1] = '{2'b01, 8'hA5, 8'h5A, 8'h0F, 8'hF0, 8'h5A, 1'b1};
    vt[2] = '{2'b01, 8'hA5, 8'hC3, 8'h0F, 8'hF0, 8'hC3, 1'b0};
    vt[3] = '{2'b10, 8'hA5, 8'hC3, 8'h7E, 8'hF0, 8'h7E, 1'b1};
    vt[4] = '{2'b11, 8'hA5, 8'hC3, 8'h7E, 8'h81, 8'h81, 1'b1};
    vt[5] = '{2'b00, 8'hFF, 8'hC3, 8'h7E, 8'h81, 8'hFF, 1'b1};
    vt[6] = '{2'b00, 8'h00, 8'hC3, 8'h7E, 8'h81, 8'h00, 1'b0};
    vt[7] = '{2'b11, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1};

    rst = 1'b1; sel = 2'b00;
    a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
    #1;
    chk("rst_mout", mr, 8'h00);
    chk("rst_selq", sqr, 2'b00);
    chk("rst_chg", chr, 1'b0);
    sel = 2'b10; c = 8'h99;
    tick(); tick();
    chk("rst_hold_mout", mr, 8'h00);
    chk("rst_hold_selq", sqr, 2'b00);
    chk("rst_hold_chg", chr, 1'b0);
    sel = 2'b00;
    rst = 1'b0;

    // table vectors
    for (int i = 0; i < 8; i++) begin
      sel = vt[i].sel;
      a = vt[i].a; b = vt[i].b;
      c = vt[i].c; d = vt[i].d;
      #1;
      chk($sformatf("v%0d_comb", i), mc, vt[i].mo);
      tick();
      chk($sformatf("v%0d_mout", i), mr, vt[i].mo);
      chk($sformatf("v%0d_selq", i), sqr, vt[i].sel);
      chk($sformatf("v%0d_chg", i), chr, vt[i].chg);
      chk($sformatf("v%0d_selq_c", i), sqc, vt[i].sel);
    end

    // mid-cycle input change must not reach registers
    sel = 2'b01; b = 8'h6D;
    #2;
    chk("midcyc_mout", mr, 8'h00);
    chk("midcyc_selq", sqr, 2'b11);
    chk("midcyc_comb", mc, 8'h6D);
    tick();
    chk("midcyc_next", mr, 8'h6D);

    // long holds per select code
    a = 8'hFF; b = 8'h00; c = 8'hFF; d = 8'h00;
    sel = 2'b00;
    tick(); tick();
    for (int s = 0; s < 4; s++) begin
      hold = mr;
      sel = 2'(s);
      #1;
      chk($sformatf("hold%0d_pre", s), mr, hold);
      for (int k = 0; k < 100; k++) begin
        tick();
        chk($sformatf("hold%0d_mout", s), mr,
            (s % 2 == 0) ? 8'hFF : 8'h00);
        chk($sformatf("hold%0d_chg", s), chr,
            (k == 0 && s != 0) ? 1'b1 : 1'b0);
      end
    end

    // random data, sel stepping every 10 cycles
    for (int cy = 0; cy < 40; cy++) begin
      #($urandom_range(1, 3));
      if (cy % 10 == 0) sel = 2'(cy / 10);
      a = 8'($urandom); b = 8'($urandom);
      c = 8'($urandom); d = 8'($urandom);
      exp = pick(sel, a, b, c, d);
      tick();
      chk("rand_mout", mr, exp);
    end

    // 00 -> 01 -> 01 -> 11 pulse sequence
    sel = 2'b00;
    tick(); tick();
    sel = 2'b01; tick();
    chk("seq1_chg", chr, 1'b1);
    chk("seq1_selq", sqr, 2'b01);
    sel = 2'b01; tick();
    chk("seq2_chg", chr, 1'b0);
    chk("seq2_selq", sqr, 2'b01);
    sel = 2'b11; tick();
    chk("seq3_chg", chr, 1'b1);
    chk("seq3_selq", sqr, 2'b11);
    tick();
    chk("seq4_chg", chr, 1'b0);

    // change every cycle keeps pulse high
    for (int k = 0; k < 8; k++) begin
      sel = sel + 2'd1;
      a = 8'($urandom);
      tick();
      chk("every_chg", chr, 1'b1);
    end

    // data toggles alone never pulse
    for (int k = 0; k < 6; k++) begin
      a = ~a; b = ~b; c = ~c; d = ~d;
      tick();
      chk("data_chg", chr, 1'b0);
    end

    // async reset with mout=1 bits and sel_q=11
    sel = 2'b11; d = 8'hFF;
    tick(); tick();
    chk("pre_rst_mout", mr, 8'hFF);
    chk("pre_rst_selq", sqr, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_mout", mr, 8'h00);
    chk("arst_selq", sqr, 2'b00);
    chk("arst_chg", chr, 1'b0);
    chk("arst_comb", mc, 8'hFF);
    tick();
    chk("arst_hold", mr, 8'h00);
    rst = 1'b0;
    tick();
    chk("rel11_chg", chr, 1'b1);
    chk("rel11_selq", sqr, 2'b11);
    chk("rel11_mout", mr, 8'hFF);

    // reset discards in-flight sample, sel=00 release is quiet
    sel = 2'b10; c = 8'h3A;
    tick();
    sel = 2'b01; b = 8'h44;
    #2;
    rst = 1'b1;
    #1;
    sel = 2'b00; a = 8'h5C;
    #1;
    rst = 1'b0;
    tick();
    chk("rel00_chg", chr, 1'b0);
    chk("rel00_selq", sqr, 2'b00);
    chk("rel00_mout", mr, 8'h5C);

    // combinational mode
    a = 8'hA5; d = 8'h3C; sel = 2'b00;
    #1;
    chk("comb_a", mc, 8'hA5);
    sel = 2'b11;
    #1;
    chk("comb_d", mc, 8'h3C);
    rst = 1'b1;
    #1;
    chk("comb_rst", mc, 8'h3C);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
